// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 encodings, FSM state encoding and divide-by-zero quotient.
package riscv_m_pkg;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_DONE
    } state_t;
endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between register-file read stage, muldiv unit and write-back.
interface muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      wb_addr;
    logic            wb_en;

    modport master (
        output start, kill, op, rs1_data, rs2_data, rd_addr,
        input  busy, done, result, wb_addr, wb_en
    );

    modport slave (
        input  start, kill, op, rs1_data, rs2_data, rd_addr,
        output busy, done, result, wb_addr, wb_en
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on the shared accumulator.
// Zero latency; no flow control.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN:0]     sum;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] shl;

    always_comb begin
        sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
        shl  = {acc_in[2*XLEN-2:0], 1'b0};
        // The bit shifted out of the partial remainder is the 33rd bit of the trial minuend.
        diff = {acc_in[2*XLEN-1], shl[2*XLEN-1:XLEN]} - {1'b0, opnd};
        if (is_div) begin
            acc_out = diff[XLEN] ? shl : {diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
        end else begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit; fixed XLEN+2 cycle start-to-done latency for every op.
// No backpressure: start only accepted while idle, kill aborts any op in flight.
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, opnd;
    logic [4:0]        rd_q;
    logic [2*XLEN-1:0] acc, acc_step;
    logic              sign_a, sign_b, div_zero, ovf;
    logic              busy_q, done_q, wb_en_q;
    logic [XLEN-1:0]   res_q;
    logic [4:0]        wb_addr_q;

    logic              accept, is_div, signed_a, signed_b, sa, sb;
    logic [XLEN-1:0]   abs_a, abs_b, quo, rem, res_fix;
    logic [2*XLEN-1:0] prod;

    // The done cycle is spent in IDLE, so a start arriving alongside done is dropped.
    assign accept = (state == ST_IDLE) && bus.start && !done_q;
    assign is_div = op_q[2];

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .opnd    (opnd),
        .acc_out (acc_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_PREP;
            ST_PREP: state_nx = bus.kill ? ST_IDLE : ST_CALC;
            ST_CALC: begin
                if (bus.kill)                     state_nx = ST_IDLE;
                else if (cnt == CW'(XLEN - 1))    state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        signed_a = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
        signed_b = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        sa       = signed_a & a_q[XLEN-1];
        sb       = signed_b & b_q[XLEN-1];
        abs_a    = sa ? -a_q : a_q;
        abs_b    = sb ? -b_q : b_q;
    end

    always_comb begin
        prod    = (sign_a ^ sign_b) ? -acc : acc;
        quo     = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem     = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res_fix = rem;
        case (op_q)
            OP_MUL:                      res_fix = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_fix = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             res_fix = div_zero ? DIV_ZERO_Q : (ovf ? MIN_NEG : quo);
            default:                     res_fix = div_zero ? a_q : (ovf ? '0 : rem);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            opnd      <= '0;
            acc       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            res_q     <= '0;
            wb_addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= bus.op;
                        a_q  <= bus.rs1_data;
                        b_q  <= bus.rs2_data;
                        rd_q <= bus.rd_addr;
                    end
                end
                ST_PREP: begin
                    sign_a   <= sa;
                    sign_b   <= sb;
                    // Multiplier (B) sits in the low half; dividend (A) does for division.
                    acc      <= is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                    opnd     <= is_div ? abs_b : abs_a;
                    div_zero <= (b_q == '0);
                    ovf      <= signed_b && is_div && (a_q == MIN_NEG) && (b_q == '1);
                    cnt      <= '0;
                end
                ST_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase

            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            if (state == ST_DONE && !bus.kill) begin
                res_q     <= res_fix;
                done_q    <= 1'b1;
                wb_en_q   <= (rd_q != 5'd0);
                wb_addr_q <= rd_q;
            end

            if (accept)                             busy_q <= 1'b1;
            else if (bus.kill && state != ST_IDLE)  busy_q <= 1'b0;
            else if (done_q)                        busy_q <= 1'b0;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = res_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_en   = wb_en_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic vectors, latency, kill, reset and handshake corners.
module tb_muldiv_unit;
    import riscv_m_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    // Drives one op and waits for done; lat counts clock edges from the accepting edge to done.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output int lat,
                         output logic we, output logic [4:0] wa, output logic bz,
                         output logic after);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (bus.done) begin
                lat = c - 1;
                break;
            end
            @(negedge clk);
        end
        res = bus.result; we = bus.wb_en; wa = bus.wb_addr; bz = bus.busy;
        @(negedge clk);
        after = bus.done | bus.busy;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
        checks++; if (bus.wb_en !== 1'b0) $display("FAIL reset_wb_en: got %b want 0", bus.wb_en); else passed++;
        checks++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 0", bus.result); else passed++;
        checks++; if (bus.wb_addr !== 5'h0) $display("FAIL reset_wb_addr: got %h want 0", bus.wb_addr); else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul;
        logic [31:0] r; int lat; logic we, bz, aft; logic [4:0] wa;
        do_op(OP_MUL, 32'd7, 32'd6, 5'd5, r, lat, we, wa, bz, aft);
        checks++; if (r !== 32'd42) $display("FAIL mul_result: got %h want %h", r, 32'd42); else passed++;
        checks++; if (lat !== 34) $display("FAIL mul_latency: got %0d want 34", lat); else passed++;
        checks++; if (we !== 1'b1) $display("FAIL mul_wb_en: got %b want 1", we); else passed++;
        checks++; if (wa !== 5'd5) $display("FAIL mul_wb_addr: got %0d want 5", wa); else passed++;
        checks++; if (bz !== 1'b1) $display("FAIL mul_busy_at_done: got %b want 1", bz); else passed++;
        checks++; if (aft !== 1'b0) $display("FAIL mul_done_pulse: done|busy after done got %b want 0", aft); else passed++;
    endtask

    task automatic test_arith;
        logic [2:0]  ops [19] = '{OP_MULH, OP_MULHU, OP_MULHSU, OP_MUL, OP_MULHU,
                                  OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM,
                                  OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM,
                                  OP_DIVU, OP_REMU};
        logic [31:0] va  [19] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7,
                                  32'h00001234, 32'd5, 32'd9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000,
                                  32'h80000000, 32'hFFFFFFFF};
        logic [31:0] vb  [19] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd5, 32'h80000000,
                                  32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                  32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'h80000001};
        logic [31:0] ve  [19] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h40000000,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1,
                                  32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h00000000,
                                  32'h00000000, 32'h7FFFFFFE};
        logic [31:0] r; int lat; logic we, bz, aft; logic [4:0] wa;
        for (int i = 0; i < 19; i++) begin
            do_op(ops[i], va[i], vb[i], 5'd10, r, lat, we, wa, bz, aft);
            checks++; if (r !== ve[i]) $display("FAIL arith_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, ops[i], va[i], vb[i], r, ve[i]); else passed++;
            checks++; if (lat !== 34) $display("FAIL arith_latency[%0d]: got %0d want 34", i, lat); else passed++;
        end
    endtask

    task automatic test_rd_zero;
        logic [31:0] r; int lat; logic we, bz, aft; logic [4:0] wa;
        do_op(OP_MUL, 32'd3, 32'd3, 5'd0, r, lat, we, wa, bz, aft);
        checks++; if (lat !== 34) $display("FAIL rd0_done: latency got %0d want 34", lat); else passed++;
        checks++; if (r !== 32'd9) $display("FAIL rd0_result: got %h want 9", r); else passed++;
        checks++; if (we !== 1'b0) $display("FAIL rd0_wb_en: got %b want 0", we); else passed++;
        checks++; if (wa !== 5'd0) $display("FAIL rd0_wb_addr: got %0d want 0", wa); else passed++;
    endtask

    task automatic test_done_cycle_start;
        logic [31:0] r; int lat; logic we, bz, aft; logic [4:0] wa;
        logic seen = 1'b0;
        int dn = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_data = 32'd2; bus.rs2_data = 32'd3; bus.rd_addr = 5'd1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (bus.done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1) $display("FAIL dcs_first_done: got %b want 1", seen); else passed++;
        checks++; if (bus.result !== 32'd6) $display("FAIL dcs_first_result: got %h want 6", bus.result); else passed++;
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_data = 32'd5; bus.rs2_data = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL dcs_start_ignored: busy got %b want 0", bus.busy); else passed++;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        checks++; if (dn !== 0) $display("FAIL dcs_no_spurious_done: got %0d want 0", dn); else passed++;
        do_op(OP_MUL, 32'd5, 32'd5, 5'd2, r, lat, we, wa, bz, aft);
        checks++; if (r !== 32'd25) $display("FAIL dcs_next_result: got %h want %h", r, 32'd25); else passed++;
    endtask

    task automatic test_kill;
        int dn = 0;
        logic [31:0] r; int lat; logic we, bz, aft; logic [4:0] wa;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9; bus.rd_addr = 5'd7;
        @(negedge clk);
        bus.start = 1'b0;
        // Eleven more edges put the unit in CALC with the counter at 10.
        repeat (11) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL kill_busy: got %b want 0", bus.busy); else passed++;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        checks++; if (dn !== 0) $display("FAIL kill_no_done: got %0d want 0", dn); else passed++;
        checks++; if (bus.result !== 32'd25) $display("FAIL kill_result_held: got %h want %h", bus.result, 32'd25); else passed++;
        // Start and kill together in IDLE: the start is taken.
        @(negedge clk);
        bus.start = 1'b1; bus.kill = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd50; bus.rs2_data = 32'd5; bus.rd_addr = 5'd8;
        @(negedge clk);
        bus.start = 1'b0; bus.kill = 1'b0;
        checks++; if (bus.busy !== 1'b1) $display("FAIL kill_start_wins: busy got %b want 1", bus.busy); else passed++;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (bus.done) begin lat = c - 1; break; end
            @(negedge clk);
        end
        checks++; if (lat !== 34) $display("FAIL kill_start_latency: got %0d want 34", lat); else passed++;
        checks++; if (bus.result !== 32'd10) $display("FAIL kill_start_result: got %h want %h", bus.result, 32'd10); else passed++;
    endtask

    task automatic test_busy_ignore;
        int dn = 0;
        logic seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd4; bus.rd_addr = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_addr = 5'd4;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1) $display("FAIL busy_ign_done: got %b want 1", seen); else passed++;
        checks++; if (bus.result !== 32'd12) $display("FAIL busy_ign_result: got %h want %h", bus.result, 32'd12); else passed++;
        checks++; if (bus.wb_addr !== 5'd3) $display("FAIL busy_ign_wb_addr: got %0d want 3", bus.wb_addr); else passed++;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        checks++; if (dn !== 0) $display("FAIL busy_ign_second_op: got %0d dones want 0", dn); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; int lat; logic we, bz, aft; logic [4:0] wa;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_addr = 5'd4;
        @(negedge clk);
        bus.start = 1'b0;
        // Six more edges: CALC with the counter at 5.
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", bus.done); else passed++;
        checks++; if (bus.result !== 32'h0) $display("FAIL rstmid_result: got %h want 0", bus.result); else passed++;
        checks++; if (bus.wb_addr !== 5'h0) $display("FAIL rstmid_wb_addr: got %h want 0", bus.wb_addr); else passed++;
        @(negedge clk);
        rst = 1'b1;
        do_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, r, lat, we, wa, bz, aft);
        checks++; if (r !== 32'hFFFFFFFE) $display("FAIL rstmid_after_result: got %h want %h", r, 32'hFFFFFFFE); else passed++;
        checks++; if (lat !== 34) $display("FAIL rstmid_after_latency: got %0d want 34", lat); else passed++;
        checks++; if (wa !== 5'd9) $display("FAIL rstmid_after_wb_addr: got %0d want 9", wa); else passed++;
    endtask

    initial begin
        bus.start = 1'b0; bus.kill = 1'b0; bus.op = 3'd0;
        bus.rs1_data = 32'd0; bus.rs2_data = 32'd0; bus.rd_addr = 5'd0;
        test_reset();
        test_mul();
        test_arith();
        test_rd_zero();
        test_done_cycle_start();
        test_kill();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
